// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display: digit count,
// blank/dash patterns and the BCD-to-segment lookup (active-low {g,f,e,d,c,b,a}).
package seg_pkg;

    localparam int NUM_DIGITS = 7;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Full 16-entry table so every nibble decodes; 10..15 render as a dash.
    localparam logic [6:0] BCD_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low segment decoder.
module bcd_to_seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);
    import seg_pkg::*;

    always_comb begin
        seg_n = BCD_SEG[bcd];
    end

endmodule

// File: rtl/seg_display.sv
// Multiplexed seven-segment display driver with frame-synchronous content
// updates, leading-zero suppression and per-digit blinking.
module seg_display #(
    parameter int NUM_DIGITS = seg_pkg::NUM_DIGITS,
    parameter int BLINK_HALF = 71
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              scan_idx,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic                    upd_done
);
    import seg_pkg::*;

    localparam int         CNT_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [2:0]              idx_q;
    logic                    pend;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blink;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blink;
    logic [CNT_W-1:0]        frame_cnt;
    logic                    blink_phase;

    logic                    boundary;
    logic                    commit;
    logic                    lz_acc;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;
    logic                    cur_valid;
    logic                    blank;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   dig_next;

    assign boundary = (idx_q == LAST_IDX) && (scan_idx == 3'd0);
    assign commit   = boundary && pend;

    // A load coinciding with a commit still sees the old pending contents
    // on the right-hand side, so the old data commits and the new data is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            pend        <= 1'b0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_blink  <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
            disp_blink  <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            upd_done    <= 1'b0;
        end else begin
            idx_q    <= scan_idx;
            upd_done <= commit;
            if (commit) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                disp_blink <= pend_blink;
            end
            if (load) begin
                pend_data  <= data;
                pend_dp    <= dp_in;
                pend_blink <= blink_en;
                pend       <= 1'b1;
            end else if (commit) begin
                pend <= 1'b0;
            end
            if (boundary) begin
                if (frame_cnt == CNT_W'(BLINK_HALF - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // lead_zero[i] is set when digits NUM_DIGITS-1 down to i are all zero.
    always_comb begin
        lz_acc    = 1'b1;
        lead_zero = '0;
        cur_bcd   = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        cur_valid = 1'b0;
        dig_next  = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_acc       = lz_acc && (disp_data[4*i +: 4] == 4'd0);
            lead_zero[i] = lz_acc;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_valid   = 1'b1;
                cur_bcd     = disp_data[4*i +: 4];
                cur_dp      = disp_dp[i];
                cur_blink   = disp_blink[i];
                cur_lz      = (i != 0) && lead_zero[i];
                dig_next[i] = 1'b0;
            end
        end
    end

    bcd_to_seg u_dec (
        .bcd   (cur_bcd),
        .seg_n (dec_seg)
    );

    assign blank    = !cur_valid || (blank_lz && cur_lz) || (cur_blink && blink_phase);
    assign seg_next = blank ? SEG_BLANK : dec_seg;
    assign dp_next  = blank ? 1'b1 : ~cur_dp;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
            dig_n <= '1;
        end else begin
            seg_n <= seg_next;
            dp_n  <= dp_next;
            dig_n <= dig_next;
        end
    end

endmodule

// File: tb/tb_seg_display.sv
// Self-checking bench for seg_display: a frame-level reference model checked
// every cycle, plus directed scan frames with hand-computed segment values.
module tb_seg_display;

    localparam int ND = 7;
    localparam int BH = 2;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [2:0]  scan_idx = 3'd0;
    logic        load     = 1'b0;
    logic [27:0] data     = '0;
    logic [6:0]  dp_in    = '0;
    logic [6:0]  blink_en = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [6:0]  dig_n;
    logic        upd_done;

    seg_display #(.NUM_DIGITS(ND), .BLINK_HALF(BH)) dut (
        .clk      (clk),
        .rst      (rst),
        .scan_idx (scan_idx),
        .load     (load),
        .data     (data),
        .dp_in    (dp_in),
        .blink_en (blink_en),
        .blank_lz (blank_lz),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .dig_n    (dig_n),
        .upd_done (upd_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int upd_seen = 0;

    logic [6:0] cap_seg [ND];
    logic       cap_dp  [ND];
    logic [6:0] cap_dig [ND];

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };
    localparam logic [6:0] WALK [ND] = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h3F};

    // Reference model state: whole digits as integers, boundary count since reset.
    bit         m_valid = 1'b0;
    int         m_prev;
    int         m_disp [ND];
    bit         m_dp   [ND];
    bit         m_bl   [ND];
    int         m_pd   [ND];
    bit         m_pdp  [ND];
    bit         m_pbl  [ND];
    bit         m_pend;
    int         m_frames;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [6:0] exp_dig;
    logic       exp_upd;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Outputs after each edge reflect the digit index seen on the previous edge.
    always @(posedge clk) begin
        bit bnd;
        bit blank;
        int top;
        if (rst) begin
            m_valid  = 1'b1;
            exp_seg  = 7'h7F;
            exp_dp   = 1'b1;
            exp_dig  = 7'h7F;
            exp_upd  = 1'b0;
            m_prev   = 0;
            m_pend   = 1'b0;
            m_frames = 0;
            for (int i = 0; i < ND; i++) begin
                m_disp[i] = 0; m_dp[i] = 0; m_bl[i] = 0;
                m_pd[i] = 0; m_pdp[i] = 0; m_pbl[i] = 0;
            end
        end else begin
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            exp_dig = 7'h7F;
            if (m_prev < ND) begin
                top = -1;
                for (int i = 0; i < ND; i++) if (m_disp[i] != 0) top = i;
                blank = (blank_lz && m_prev >= 1 && m_prev > top) ||
                        (m_bl[m_prev] && ((m_frames / BH) % 2 == 1));
                exp_dig[m_prev] = 1'b0;
                if (!blank) begin
                    exp_seg = SEG_TAB[m_disp[m_prev]];
                    exp_dp  = !m_dp[m_prev];
                end
            end
            bnd     = (m_prev == ND - 1) && (scan_idx == 3'd0);
            exp_upd = bnd && m_pend;
            if (bnd) m_frames++;
            if (bnd && m_pend) begin
                for (int i = 0; i < ND; i++) begin
                    m_disp[i] = m_pd[i]; m_dp[i] = m_pdp[i]; m_bl[i] = m_pbl[i];
                end
                m_pend = 1'b0;
            end
            if (load) begin
                for (int i = 0; i < ND; i++) begin
                    m_pd[i] = int'(data[4*i +: 4]); m_pdp[i] = dp_in[i]; m_pbl[i] = blink_en[i];
                end
                m_pend = 1'b1;
            end
            m_prev = int'(scan_idx);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("cyc_seg_n", 32'(seg_n), 32'(exp_seg));
            checkOutput("cyc_dp_n", 32'(dp_n), 32'(exp_dp));
            checkOutput("cyc_dig_n", 32'(dig_n), 32'(exp_dig));
            checkOutput("cyc_upd_done", 32'(upd_done), 32'(exp_upd));
            if (upd_done === 1'b1) upd_seen++;
        end
    end

    task automatic applyStimulus(input logic [27:0] d, input logic [6:0] dp, input logic [6:0] bl);
        load     = 1'b1;
        data     = d;
        dp_in    = dp;
        blink_en = bl;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Scans digits first..last, two cycles each, optionally loading on the first step.
    task automatic scanRange(input int first, input int last, input bit ld,
                             input logic [27:0] d, input logic [6:0] dp, input logic [6:0] bl);
        for (int k = first; k <= last; k++) begin
            scan_idx = 3'(k);
            if (ld && k == first) applyStimulus(d, dp, bl);
            else @(negedge clk);
            @(negedge clk);
            cap_seg[k] = seg_n;
            cap_dp[k]  = dp_n;
            cap_dig[k] = dig_n;
        end
    endtask

    initial begin
        int u0;
        repeat (2) @(negedge clk);
        checkOutput("rst_seg_n", 32'(seg_n), 32'h7F);
        checkOutput("rst_dp_n", 32'(dp_n), 32'h1);
        checkOutput("rst_dig_n", 32'(dig_n), 32'h7F);
        checkOutput("rst_upd_done", 32'(upd_done), 32'h0);
        rst = 1'b0;

        scanRange(0, 6, 0, '0, '0, '0);
        for (int k = 0; k < ND; k++) begin
            checkOutput($sformatf("zero_seg_d%0d", k), 32'(cap_seg[k]), 32'h40);
            checkOutput($sformatf("zero_dig_d%0d", k), 32'(cap_dig[k]), 32'(WALK[k]));
        end

        u0 = upd_seen;
        scanRange(0, 2, 0, '0, '0, '0);
        scanRange(3, 6, 1, 28'h0001234, '0, '0);
        checkOutput("pre_commit_d4", 32'(cap_seg[4]), 32'h40);
        checkOutput("pre_commit_d6", 32'(cap_seg[6]), 32'h40);
        scanRange(0, 6, 0, '0, '0, '0);
        checkOutput("d1234_d0", 32'(cap_seg[0]), 32'h19);
        checkOutput("d1234_d1", 32'(cap_seg[1]), 32'h30);
        checkOutput("d1234_d2", 32'(cap_seg[2]), 32'h24);
        checkOutput("d1234_d3", 32'(cap_seg[3]), 32'h79);
        checkOutput("d1234_upd_count", 32'(upd_seen - u0), 32'd1);

        blank_lz = 1'b1;
        scanRange(0, 1, 0, '0, '0, '0);
        scanRange(2, 6, 1, 28'h0000050, '0, '0);
        scanRange(0, 6, 0, '0, '0, '0);
        checkOutput("lz_d0", 32'(cap_seg[0]), 32'h40);
        checkOutput("lz_d1", 32'(cap_seg[1]), 32'h12);
        for (int k = 2; k < ND; k++)
            checkOutput($sformatf("lz_blank_d%0d", k), 32'(cap_seg[k]), 32'h7F);
        checkOutput("lz_dp_d0", 32'(cap_dp[0]), 32'h1);

        blank_lz = 1'b0;
        scanRange(0, 0, 0, '0, '0, '0);
        u0 = upd_seen;
        scanRange(1, 3, 1, 28'h1111111, '0, '0);
        scanRange(4, 6, 1, 28'h2222222, 7'h04, '0);
        scanRange(0, 6, 0, '0, '0, '0);
        for (int k = 0; k < ND; k++)
            checkOutput($sformatf("last_wins_d%0d", k), 32'(cap_seg[k]), 32'h24);
        checkOutput("last_wins_dp_d2", 32'(cap_dp[2]), 32'h0);
        checkOutput("last_wins_dp_d1", 32'(cap_dp[1]), 32'h1);
        checkOutput("last_wins_upd_count", 32'(upd_seen - u0), 32'd1);

        scanRange(0, 0, 0, '0, '0, '0);
        scanRange(1, 6, 1, 28'h2222222, '0, 7'h01);
        for (int f = 9; f <= 12; f++) begin
            scanRange(0, 6, 0, '0, '0, '0);
            checkOutput($sformatf("blink_f%0d_d0", f), 32'(cap_seg[0]), (f >= 11) ? 32'h7F : 32'h24);
            checkOutput($sformatf("blink_f%0d_d1", f), 32'(cap_seg[1]), 32'h24);
        end
        scanRange(0, 2, 0, '0, '0, '0);
        checkOutput("blink_f13_d0", 32'(cap_seg[0]), 32'h24);
        scanRange(3, 6, 1, 28'h4444444, '0, '0);

        u0 = upd_seen;
        scanRange(0, 3, 1, 28'h3333333, '0, '0);
        checkOutput("coincide_d0", 32'(cap_seg[0]), 32'h19);
        checkOutput("coincide_upd_count", 32'(upd_seen - u0), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_seg_n", 32'(seg_n), 32'h7F);
        checkOutput("midrst_dig_n", 32'(dig_n), 32'h7F);
        checkOutput("midrst_upd_done", 32'(upd_done), 32'h0);
        rst = 1'b0;
        u0 = upd_seen;
        scanRange(0, 6, 0, '0, '0, '0);
        scanRange(0, 6, 0, '0, '0, '0);
        checkOutput("discard_upd_count", 32'(upd_seen - u0), 32'd0);
        checkOutput("discard_d0", 32'(cap_seg[0]), 32'h40);
        checkOutput("discard_d3", 32'(cap_seg[3]), 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display.md
SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 Parameter NUM_DIGITS, default 7: number of multiplexed digits, indices 0 (least significant) to 6.
REQ-002 Parameter BLINK_HALF, default 71: frames per blink half-period.
REQ-003 Ports: clk  in  1  system clock, the only clock.
REQ-004 Ports: rst  in  1  synchronous active-high reset.
REQ-005 Ports: scan_idx  in  3  digit index from the scan counter, sequence 0..6, synchronous to clk.
REQ-006 Ports: load  in  1  single-cycle request to capture new display contents.
REQ-007 Ports: data  in  28  seven BCD digits, digit i at data[4i+3:4i].
REQ-008 Ports: dp_in  in  7  per-digit decimal point, 1 = lit.
REQ-009 Ports: blink_en  in  7  per-digit blink mask.
REQ-010 Ports: blank_lz  in  1  leading-zero suppression enable.
REQ-011 Ports: seg_n  out  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-012 Ports: dp_n  out  1  active-low decimal point, registered.
REQ-013 Ports: dig_n  out  7  active-low digit enables, at most one low, registered.
REQ-014 Ports: upd_done  out  1  one-cycle pulse when pending contents are committed to the display.

Function
REQ-015 idx_q SHALL register scan_idx every cycle; a step is any cycle where scan_idx != idx_q.
REQ-016 A frame boundary SHALL be the cycle where idx_q == 6 and scan_idx == 0.
REQ-017 load SHALL capture data, dp_in and blink_en into pending registers and set pend; a load while pend = 1 SHALL overwrite the pending contents (last wins).
REQ-018 At a frame boundary with pend = 1, the pending contents SHALL be copied to the display registers, pend SHALL clear and upd_done SHALL pulse one cycle later.
REQ-019 When load and frame boundary coincide, the old pending contents SHALL commit, the new load SHALL be captured, and pend SHALL remain 1 until the next boundary.
REQ-020 Frame counter SHALL increment at each frame boundary; at BLINK_HALF-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-021 Outputs SHALL update every cycle from idx_q, giving 2 clk cycles of latency from a scan_idx change to seg_n/dig_n.
REQ-022 dig_n SHALL drive bit idx_q low; idx_q == 7 SHALL drive dig_n = 7'h7F and seg_n = 7'h7F.
REQ-023 Decoding SHALL be: BCD 0..9 to standard segments (0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00); values 10..15 SHALL show a dash, 7'h3F.
REQ-024 With blank_lz = 1, digit i (i >= 1) SHALL be blank (seg_n 7'h7F, dp_n 1) when digits 6 down to i are all zero; digit 0 SHALL never be suppressed.
REQ-025 Digit i SHALL be blank, including dp, when blink_en[i] = 1 and blink_phase = 1.
REQ-026 dp_n SHALL equal ~dp of the displayed digit unless that digit is blanked.

Reset
REQ-027 On rst, the following SHALL apply at the next edge: seg_n = 7'h7F, dp_n = 1, dig_n = 7'h7F, upd_done = 0, pend = 0, display and pending registers = 0, idx_q = 0, frame counter = 0, blink_phase = 0.
REQ-028 Reset mid-operation SHALL discard pending loads without asserting upd_done.

Structure
REQ-029 Package seg_pkg SHALL hold NUM_DIGITS, the segment constants SEG_BLANK (7'h7F) and SEG_DASH (7'h3F), and the BCD-to-segment table.
REQ-030 Combinational sub-module bcd_to_seg (4-bit in, 7-bit active-low out) SHALL perform the decoding.

Verification
REQ-031 Reset, then scan 0..6 with data = 0x0000000 and blank_lz = 0 -> each digit shows 7'h40 and dig_n walks 7'h7E, 7'h7D, ... 7'h3F with 2-cycle latency.
REQ-032 Load 0x0001234 mid-frame -> display unchanged until the next 6->0 boundary; upd_done pulses once; digits 0..3 then show 4, 3, 2, 1.
REQ-033 blank_lz = 1 with data 0x0000050 -> digits 2..6 show 7'h7F, digit 1 shows 5, digit 0 shows 7'h40.
REQ-034 Two loads before one boundary (0x1111111 then 0x2222222) -> only 2s are displayed and upd_done pulses once.
REQ-035 blink_en = 7'h01 with BLINK_HALF = 2 -> digit 0 blanks in alternate 2-frame windows while the other digits stay lit.
REQ-036 Load coincident with a boundary, then rst asserted before the next boundary -> no upd_done, and outputs are 7'h7F.
